sprite_anim_renderer: RTL and testbench

- Parametrised sprite pixel generator for the VGA pipeline.
- Maps the current DrawX/DrawY onto one animated sprite sheet held in an external synchronous ROM.
- Supports arbitrary screen position, power-of-two integer scaling, horizontal flip, a transparency index and frame-locked animation.
- Emits a palette index plus a hit flag to the downstream compositor/palette stage.

---
 rtl/sprite_anim_renderer.sv | 160 ++++++++++++++++
 tb/tb_sprite_anim_renderer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_renderer.sv
// Sprite pixel generator: maps DrawX/DrawY onto an animated sprite sheet in sync ROM.
// Optional debug outline enabled by defining SPRITE_BBOX_EN (adds BBOX_IDX).
module sprite_anim_renderer #(
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int FRAMES     = 4,
  parameter int IDX_W      = 3,
  parameter int SCALE_LOG2 = 1,
  parameter int FRAME_DIV  = 8,
  parameter int TRANSP_IDX = 0,
`ifdef SPRITE_BBOX_EN
  parameter int BBOX_IDX   = 7,
`endif
  parameter int ADDR_W     = $clog2(SPR_W*SPR_H*FRAMES),
  localparam int FW        = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              sprite_en,
  input  logic              flip_h,
  input  logic              anim_run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic              hit,
  output logic [IDX_W-1:0]  pix_idx,
  output logic [FW-1:0]     anim_frame
);

  localparam int XB = $clog2(SPR_W);
  localparam int YB = $clog2(SPR_H);
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [10:0] L_BW = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0] L_BH = 11'(SPR_H << SCALE_LOG2);
  localparam logic [IDX_W-1:0] L_TRANSP = IDX_W'(TRANSP_IDX);

  logic [9:0]        r_sx, r_sy;
  logic              r_en, r_flip;
  logic [DW-1:0]     r_div;
  logic [FW-1:0]     r_frame;
  logic [ADDR_W-1:0] r_addr;
  logic              r_in1, r_bl1, r_in2, r_bl2;
  logic              r_hit;
  logic [IDX_W-1:0]  r_pix;

  logic              w_tick;
  logic [10:0]       w_x, w_y, w_sx, w_sy, w_dx, w_dy;
  logic              w_in_x, w_in_y, w_in_box;
  logic [XB-1:0]     w_lx, w_lxf;
  logic [YB-1:0]     w_ly;
  logic [FW+YB+XB-1:0] w_addr_full;
  logic              w_hit_nxt;
  logic [IDX_W-1:0]  w_pix_nxt;

  assign w_tick = (DrawX == 10'd0) && (DrawY == 10'd0);

  // Shadow registers and animation only move on the frame tick
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      r_sx    <= '0;
      r_sy    <= '0;
      r_en    <= 1'b0;
      r_flip  <= 1'b0;
      r_div   <= '0;
      r_frame <= '0;
    end else if (w_tick) begin
      r_sx   <= sprite_x;
      r_sy   <= sprite_y;
      r_en   <= sprite_en;
      r_flip <= flip_h;
      if (anim_run) begin
        if (r_div == DW'(FRAME_DIV - 1)) begin
          r_div   <= '0;
          r_frame <= (r_frame == FW'(FRAMES - 1)) ? '0 : r_frame + 1'b1;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  assign w_x  = {1'b0, DrawX};
  assign w_y  = {1'b0, DrawY};
  assign w_sx = {1'b0, r_sx};
  assign w_sy = {1'b0, r_sy};

  // 11-bit compares so boxes past the right/bottom edge clip instead of wrapping
  assign w_in_x   = (w_x >= w_sx) && (w_x < w_sx + L_BW);
  assign w_in_y   = (w_y >= w_sy) && (w_y < w_sy + L_BH);
  assign w_in_box = r_en && w_in_x && w_in_y;

  assign w_dx  = w_x - w_sx;
  assign w_dy  = w_y - w_sy;
  assign w_lx  = XB'(w_dx >> SCALE_LOG2);
  assign w_ly  = YB'(w_dy >> SCALE_LOG2);
  assign w_lxf = r_flip ? ~w_lx : w_lx;

  assign w_addr_full = {r_frame, w_ly, w_lxf};

`ifdef SPRITE_BBOX_EN
  logic w_edge;
  logic r_edge1, r_edge2;

  assign w_edge = (w_x == w_sx) || (w_x == w_sx + L_BW - 11'd1) ||
                  (w_y == w_sy) || (w_y == w_sy + L_BH - 11'd1);

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      r_edge1 <= 1'b0;
      r_edge2 <= 1'b0;
    end else begin
      r_edge1 <= w_edge;
      r_edge2 <= r_edge1;
    end
  end
`endif

  always_comb begin
    w_hit_nxt = r_in2 && r_bl2 && (rom_q != L_TRANSP);
    w_pix_nxt = rom_q;
`ifdef SPRITE_BBOX_EN
    if (r_in2 && r_bl2 && r_edge2) begin
      w_hit_nxt = 1'b1;
      w_pix_nxt = IDX_W'(BBOX_IDX);
    end
`endif
  end

  // S1 -> ROM -> S2; address held outside the box to keep the ROM quiet
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      r_addr <= '0;
      r_in1  <= 1'b0;
      r_bl1  <= 1'b0;
      r_in2  <= 1'b0;
      r_bl2  <= 1'b0;
      r_hit  <= 1'b0;
      r_pix  <= '0;
    end else begin
      if (w_in_box)
        r_addr <= w_addr_full[ADDR_W-1:0];
      r_in1 <= w_in_box;
      r_bl1 <= blank;
      r_in2 <= r_in1;
      r_bl2 <= r_bl1;
      r_hit <= w_hit_nxt;
      r_pix <= w_pix_nxt;
    end
  end

  assign rom_addr   = r_addr;
  assign hit        = r_hit;
  assign pix_idx    = r_pix;
  assign anim_frame = r_frame;

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Directed bench for sprite_anim_renderer with a scoreboard of expected pixels.
// Builds with or without SPRITE_BBOX_EN; the reference model follows the macro.
module tb_sprite_anim_renderer;

  typedef struct packed {
    logic       hit;
    logic [2:0] pix;
  } exp_t;

  logic        clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic [9:0]  sprite_x, sprite_y;
  logic        sprite_en, flip_h, anim_run;
  logic [11:0] rom_addr;
  logic [2:0]  rom_q;
  logic        hit;
  logic [2:0]  pix_idx;
  logic [1:0]  anim_frame;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  int   m_sx, m_sy;
  bit   m_en, m_flip;
  int   exp_frame, exp_div, exp_addr;
  bit   rom_zero;

  sprite_anim_renderer dut (
    .vga_clk    (clk),
    .Reset      (Reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .sprite_en  (sprite_en),
    .flip_h     (flip_h),
    .anim_run   (anim_run),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .hit        (hit),
    .pix_idx    (pix_idx),
    .anim_frame (anim_frame)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data is the low address bits, or all transparent
  always @(posedge clk)
    rom_q <= rom_zero ? 3'd0 : rom_addr[2:0];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_en = 0; m_flip = 0;
    exp_frame = 0; exp_div = 0; exp_addr = 0;
    sb.delete();
  endtask

  // One pixel per clock: check the pixel from 3 cycles ago, then drive
  task automatic step(input int x, input int y, input bit b);
    exp_t e;
    int   lx, ly, a, pix;
    bit   inb, edg;
    @(negedge clk);
    if (sb.size() == 3) begin
      e = sb.pop_front();
      chk("hit", 32'(hit), 32'(e.hit));
      if (e.hit) chk("pix", 32'(pix_idx), 32'(e.pix));
    end
    chk("addr", 32'(rom_addr), exp_addr);
    chk("frame", 32'(anim_frame), exp_frame);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    inb = m_en && x >= m_sx && x < m_sx + 64 && y >= m_sy && y < m_sy + 64;
    e.hit = 1'b0;
    e.pix = 3'd0;
    if (inb) begin
      lx = (x - m_sx) / 2;
      ly = (y - m_sy) / 2;
      if (m_flip) lx = 31 - lx;
      a = exp_frame * 1024 + ly * 32 + lx;
      exp_addr = a;
      pix = rom_zero ? 0 : a % 8;
      e.hit = b && (pix != 0);
      e.pix = 3'(pix);
`ifdef SPRITE_BBOX_EN
      edg = (x == m_sx) || (x == m_sx + 63) || (y == m_sy) || (y == m_sy + 63);
      if (edg && b) begin
        e.hit = 1'b1;
        e.pix = 3'd7;
      end
`else
      edg = 1'b0;
`endif
    end
    sb.push_back(e);
    if (x == 0 && y == 0) begin
      m_sx = sprite_x; m_sy = sprite_y; m_en = sprite_en; m_flip = flip_h;
      if (anim_run) begin
        if (exp_div == 7) begin
          exp_div = 0;
          exp_frame = (exp_frame + 1) % 4;
        end else begin
          exp_div++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic row(input int y, input int x0, input int x1, input bit b);
    for (int x = x0; x <= x1; x++) step(x, y, b);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 1, 1'b0);
  endtask

  initial begin
    Reset = 1'b1;
    DrawX = 10'd5; DrawY = 10'd5; blank = 1'b0;
    sprite_x = '0; sprite_y = '0;
    sprite_en = 1'b0; flip_h = 1'b0; anim_run = 1'b0;
    rom_zero = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hit", 32'(hit), 0);
    chk("rst_pix", 32'(pix_idx), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_frame", 32'(anim_frame), 0);
    @(negedge clk);
    Reset = 1'b0;

    sprite_x = 10'd100; sprite_y = 10'd50; sprite_en = 1'b1;
    step(0, 0, 1'b1);
    step(101, 51, 1'b1);
    chk("addr_101_51", 32'(rom_addr), 0);
    step(102, 51, 1'b1);
    chk("addr_102_51", 32'(rom_addr), 1);
    row(51, 96, 170, 1'b1);
    row(52, 100, 120, 1'b0);
    row(113, 95, 170, 1'b1);
    row(114, 95, 110, 1'b1);

    flip_h = 1'b1;
    step(0, 0, 1'b1);
    step(100, 50, 1'b1);
    chk("flip_addr", 32'(rom_addr), 31);
    sprite_x = 10'd200;
    row(50, 100, 110, 1'b1);
    chk("midframe_hold", 32'(rom_addr), 26);
    step(0, 0, 1'b1);
    step(200, 50, 1'b1);
    chk("new_x_addr", 32'(rom_addr), 31);
    row(50, 200, 270, 1'b1);

    flip_h = 1'b0; sprite_x = 10'd600;
    step(0, 0, 1'b1);
    row(60, 590, 639, 1'b1);
    row(60, 0, 23, 1'b1);
    sprite_x = 10'd1000;
    step(0, 0, 1'b1);
    row(60, 990, 1023, 1'b1);
    row(60, 0, 40, 1'b1);
    sprite_x = 10'd100; sprite_y = 10'd1000;
    step(0, 0, 1'b1);
    row(1020, 96, 170, 1'b1);
    row(10, 96, 110, 1'b1);

    sprite_y = 10'd50;
    step(0, 0, 1'b1);
    idle(3);
    rom_zero = 1'b1;
    row(50, 96, 170, 1'b1);
    row(80, 96, 170, 1'b1);
    row(113, 96, 170, 1'b1);
    row(114, 96, 110, 1'b1);
    idle(3);
    rom_zero = 1'b0;

    anim_run = 1'b1;
    repeat (8) step(0, 0, 1'b0);
    chk("frame_after_8", 32'(anim_frame), 1);
    repeat (8) step(0, 0, 1'b0);
    chk("frame_after_16", 32'(anim_frame), 2);
    step(100, 50, 1'b1);
    chk("frame2_addr", 32'(rom_addr), 2048);
    repeat (16) step(0, 0, 1'b0);
    chk("frame_wrap", 32'(anim_frame), 0);
    repeat (8) step(0, 0, 1'b0);
    anim_run = 1'b0;
    repeat (10) step(0, 0, 1'b0);
    chk("frame_hold", 32'(anim_frame), 1);

    row(50, 100, 110, 1'b1);
    #2;
    chk("pre_rst_hit", 32'(hit), 1);
    Reset = 1'b1;
    #1;
    chk("async_rst_hit", 32'(hit), 0);
    chk("async_rst_frame", 32'(anim_frame), 0);
    chk("async_rst_addr", 32'(rom_addr), 0);
    model_reset();
    @(negedge clk);
    Reset = 1'b0;
    row(50, 100, 120, 1'b1);
    chk("no_tick_hit", 32'(hit), 0);
    step(0, 0, 1'b1);
    row(50, 96, 130, 1'b1);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
